// File: rtl/gates_sched_pkg.sv
// rtl/gates_sched_pkg.sv - shared op codes, output-stage states and default sizes
// Provides:
//   op_e        : neighbour-gate op codes carried on req_op / rsp_op
//   out_state_e : output register occupancy
//   DEF_W       : default vector width
//   DEF_N_REQ   : default requester count
package gates_sched_pkg;

  typedef enum logic [1:0] {
    OP_BOTH = 2'd0,
    OP_ANY  = 2'd1,
    OP_DIFF = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  localparam int DEF_W     = 100;
  localparam int DEF_N_REQ = 4;

endpackage

// File: rtl/gates_vec_unit.sv
// rtl/gates_vec_unit.sv - combinational neighbour-gate engine
// Ports:
//   x  in  [W]  operand vector
//   op in  [2]  op code (BOTH / ANY / DIFF / RSVD)
//   y  out [W]  result vector
module gates_vec_unit
  import gates_sched_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] x,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      // x >> 1 brings a zero into the top bit, so bit W-1 is 0.
      OP_BOTH: y = x & (x >> 1);
      // Bit 0 has no lower neighbour and is forced to 0.
      OP_ANY: begin
        y    = x | (x << 1);
        y[0] = 1'b0;
      end
      // Neighbour of the top bit wraps around to bit 0.
      OP_DIFF: y = x ^ {x[0], x[W-1:1]};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gates_vec_sched.sv
// rtl/gates_vec_sched.sv - round-robin scheduler sharing one gate engine among requesters
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   req_valid [N_REQ]      per-requester valid
//   req_ready [N_REQ]      one-hot (or zero) accept
//   req_data  [N_REQ*W]    requester i at [i*W +: W]
//   req_op    [N_REQ*2]    requester i at [i*2 +: 2]
//   rsp_valid/rsp_ready    response handshake
//   rsp_data [W], rsp_id [IDW], rsp_op [2]  registered result
//   done_cnt [CNTW]        saturating count of response handshakes
module gates_vec_sched
  import gates_sched_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDW   = $clog2(N_REQ),
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_data,
  input  logic [N_REQ*2-1:0] req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic [1:0]         rsp_op,
  output logic [CNTW-1:0]    done_cnt
);

  out_state_e     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic           gnt_found;
  logic           can_accept;
  logic           req_hs;
  logic [W-1:0]   unit_x;
  logic [W-1:0]   unit_y;
  logic [1:0]     unit_op;

  assign rsp_valid  = (state == ST_FULL);
  // The output slot frees up in the same cycle it is consumed.
  assign can_accept = !rsp_valid || rsp_ready;

  // First valid requester at or after rr_ptr; N_REQ is a power of two,
  // so the IDW-bit add wraps modulo N_REQ by itself.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = rr_ptr + IDW'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (resetn && gnt_found && can_accept) req_ready[gnt_idx] = 1'b1;
  end

  assign req_hs  = |req_ready;
  assign unit_x  = req_data[gnt_idx*W +: W];
  assign unit_op = req_op[gnt_idx*2 +: 2];

  gates_vec_unit #(.W(W)) u_unit (
    .x  (unit_x),
    .op (unit_op),
    .y  (unit_y)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_op   <= '0;
      rr_ptr   <= '0;
      done_cnt <= '0;
    end else begin
      if (rsp_valid && rsp_ready && (done_cnt != '1))
        done_cnt <= done_cnt + 1'b1;
      if (req_hs) begin
        state    <= ST_FULL;
        rsp_data <= unit_y;
        rsp_id   <= gnt_idx;
        rsp_op   <= unit_op;
        rr_ptr   <= gnt_idx + 1'b1;
      end else if (rsp_ready) begin
        // Payload fields keep their last values once drained.
        state <= ST_EMPTY;
      end
    end
  end

endmodule
